shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
- Sequencer for a LENGTH-bit serial shift register datapath.
- Accepts a parallel word over a valid/ready handshake and shifts it out LSB-first on dout at one bit per DIV clocks.
- Simultaneously captures din into the same register, then presents the captured word on a valid/ready output.
- Sits between a parallel producer/consumer and a serial link, with full-duplex loopback-capable framing.

Parameters:
- LENGTH, 8, shift register width in bits (legal range >= 2).
- DIV, 4, clocks per bit period (legal range >= 1; DIV=1 shifts every clock).

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- tx_data  in  LENGTH  parallel word to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  controller can accept a word.
- abort  in  1  synchronous cancel of the transfer in progress.
- din  in  1  serial input bit.
- dout  out  1  serial output bit (current sh[0]).
- shift_tick  out  1  high during the cycle whose ending edge performs a shift.
- busy  out  1  high in SHIFT state.
- rx_data  out  LENGTH  captured word.
- rx_valid  out  1  rx_data is valid.
- rx_ready  in  1  consumer accepts rx_data.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; sh, bit_cnt, div_cnt, rx_data = 0; rx_valid=0. Outputs: tx_ready=1, dout=0, busy=0, shift_tick=0. Reset overrides everything, including mid-transfer; no rx_valid results from an interrupted transfer.
- States: IDLE, SHIFT, WAIT_RX.
- IDLE:
  - tx_ready=1; dout=0.
  - On tx_valid=1 at posedge: sh<=tx_data, bit_cnt<=0, div_cnt<=0, state<=SHIFT.
- SHIFT:
  - tx_ready=0, busy=1, dout=sh[0].
  - div_cnt increments each clock and wraps at DIV-1.
  - shift_tick = (div_cnt==DIV-1).
  - On a tick edge: sh<={din, sh[LENGTH-1:1]}, bit_cnt<=bit_cnt+1.
  - On the tick where bit_cnt==LENGTH-1: rx_data<={din, sh[LENGTH-1:1]}, rx_valid<=1, state<=WAIT_RX.
- Timing:
  - Word accepted at edge E.
  - Bit k is on dout for clocks E+k*DIV .. E+(k+1)*DIV-1.
  - din is sampled at edge E+(k+1)*DIV.
  - rx_valid rises at edge E+LENGTH*DIV.
  - The first din bit sampled lands in rx_data[0].
- WAIT_RX:
  - tx_ready=0, busy=0, dout=0.
  - rx_data and rx_valid are held stable until rx_valid and rx_ready are both 1 at a posedge; then rx_valid<=0, state<=IDLE.
  - A new word cannot be accepted in the same cycle as the rx handshake; the earliest acceptance is the following cycle.
- abort:
  - In SHIFT: state<=IDLE next edge, sh<=0, counters<=0, rx_valid unchanged (stays 0). abort has priority over a tick on the same edge.
  - In IDLE and WAIT_RX, abort is ignored.
- tx_valid while tx_ready=0 is ignored; the producer holds the word.
- rx_ready while rx_valid=0 is ignored.
- Counter widths: bit_cnt is $clog2(LENGTH+1) bits; div_cnt is max(1,$clog2(DIV)) bits. No wrap beyond the stated terminal counts.

Decomposition:
- Package shift_seq_pkg:
  - state enum (IDLE, SHIFT, WAIT_RX);
  - width helper functions for the counters.
- Sub-module shift_seq_div: bit-period divider.
  - Inputs: clk, rst_n, en (= state==SHIFT), clr (= abort or accept).
  - Output: tick.
  - Reused by later serial blocks.

Test Plan:
- Reset mid-transfer: LENGTH=8, DIV=4; accept tx_data=8'h3C, assert rst_n=0 at cycle 10 → next edge tx_ready=1, busy=0, dout=0, rx_valid=0; no rx_valid for the next 40 cycles.
- Loopback: din tied to dout, tx_data=8'hA5 accepted at edge E → dout sequence 1,0,1,0,0,1,0,1 (4 clocks each); rx_valid rises at E+32 with rx_data=8'hA5; 8 shift_tick pulses total.
- Fixed-input capture: din=1 constant, tx_data=8'h00 → rx_data=8'hFF; din alternating per bit starting 0 → rx_data=8'hAA.
- Backpressure: hold rx_ready=0 for 20 cycles after rx_valid → rx_data stable; tx_ready=0 and tx_valid=1 ignored. Raise rx_ready → rx_valid drops next edge; new word accepted one cycle later.
- Abort: abort=1 on the cycle after the third shift_tick → IDLE next edge, tx_ready=1, rx_valid never asserts. A subsequent tx_data=8'h5A with loopback returns 8'h5A.
- DIV=1, LENGTH=2: tx_data=2'b10 with loopback → shift_tick high on 2 consecutive cycles, rx_valid at E+2, rx_data=2'b10.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types and width helpers for the serial shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    WAIT_RX
  } state_t;

  function automatic int bit_cnt_w(input int length);
    return $clog2(length + 1);
  endfunction

  function automatic int div_cnt_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/shift_seq_div.sv
// Bit-period divider: tick marks the last clock of each bit period.
module shift_seq_div
  import shift_seq_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = div_cnt_w(DIV);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Full-duplex shift sequencer: parallel word out LSB-first on dout,
// din captured into the same register and returned as rx_data.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int LENGTH = 8,
  parameter int DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LENGTH-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              abort,
  input  logic              din,
  output logic              dout,
  output logic              shift_tick,
  output logic              busy,
  output logic [LENGTH-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready
);

  localparam int BW = bit_cnt_w(LENGTH);

  state_t            state;
  state_t            state_nxt;
  logic [LENGTH-1:0] sh;
  logic [BW-1:0]     bit_cnt;
  logic              tick;
  logic              accept;
  logic              last;

  assign accept     = (state == IDLE) && tx_valid;
  assign last       = tick && (bit_cnt == BW'(LENGTH - 1));
  assign shift_tick = tick;

  shift_seq_div #(
    .DIV (DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == SHIFT),
    .clr   (abort || accept),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    busy      = 1'b0;
    dout      = 1'b0;
    unique case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        dout = sh[0];
        if (abort) state_nxt = IDLE;
        else if (last) state_nxt = WAIT_RX;
      end
      WAIT_RX: begin
        if (rx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // abort outranks a tick landing on the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh       <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (tx_valid) begin
            sh      <= tx_data;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (abort) begin
            sh      <= '0;
            bit_cnt <= '0;
          end else if (tick) begin
            sh      <= {din, sh[LENGTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (last) begin
              rx_data  <= {din, sh[LENGTH-1:1]};
              rx_valid <= 1'b1;
            end
          end
        end
        WAIT_RX: begin
          if (rx_ready) rx_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
